// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sched
// Purpose  : Multi-cycle HI/LO multiply/divide engine with pipeline stall
//            request; shift-add multiply and restoring divide, 1 bit per cycle.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_sched #(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 6,
    parameter logic [WIDTH-1:0] DZ_LO = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             stallreq,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] c_op_mult  = 4'b0101;
    localparam logic [3:0] c_op_multu = 4'b0110;
    localparam logic [3:0] c_op_div   = 4'b0111;
    localparam logic [3:0] c_op_divu  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_is_mul, w_is_div, w_is_signed, w_accept;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_prod, w_mul_fix;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem, w_div_quo, w_rem_fix, w_quo_fix;
    logic               w_last;

    assign w_is_mul    = (op == c_op_mult) || (op == c_op_multu);
    assign w_is_div    = (op == c_op_div)  || (op == c_op_divu);
    assign w_is_signed = (op == c_op_mult) || (op == c_op_div);
    assign w_accept    = (state_q == S_IDLE) && start && (w_is_mul || w_is_div) && !cancel;

    assign w_a_mag = (w_is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_mag = (w_is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply: acc_lo holds the multiplier and shifts out as product bits enter.
    assign w_mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_prod = {w_mul_sum, acc_lo_q[WIDTH-1:1]};
    assign w_mul_fix  = neg_quo_q ? -w_mul_prod : w_mul_prod;

    // Divide: remainder in acc_hi, dividend/quotient shifting through acc_lo.
    assign w_div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, opnd_q});
    assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - opnd_q) : w_div_sh[WIDTH-1:0];
    assign w_div_quo = {acc_lo_q[WIDTH-2:0], w_div_ge};
    assign w_rem_fix = neg_rem_q ? -w_div_rem : w_div_rem;
    assign w_quo_fix = neg_quo_q ? -w_div_quo : w_div_quo;

    assign w_last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    neg_quo_d = w_is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    neg_rem_d = w_is_signed && w_is_div && src_a[WIDTH-1];
                    cnt_d     = CNT_W'(WIDTH);
                    acc_hi_d  = '0;
                    if (w_is_mul) begin
                        state_d  = S_MUL;
                        opnd_d   = w_a_mag;
                        acc_lo_d = w_b_mag;
                    end else if (src_b == '0) begin
                        state_d = S_DONE;
                        hi_d    = src_a;
                        lo_d    = DZ_LO;
                    end else begin
                        state_d  = S_DIV;
                        opnd_d   = w_b_mag;
                        acc_lo_d = w_a_mag;
                    end
                end
            end
            S_MUL: begin
                {acc_hi_d, acc_lo_d} = w_mul_prod;
                cnt_d = cnt_q - CNT_W'(1);
                if (w_last) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = w_mul_fix;
                end
            end
            S_DIV: begin
                acc_hi_d = w_div_rem;
                acc_lo_d = w_div_quo;
                cnt_d    = cnt_q - CNT_W'(1);
                if (w_last) begin
                    state_d = S_DONE;
                    hi_d    = w_rem_fix;
                    lo_d    = w_quo_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything and leaves the architectural result alone.
        if (cancel) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign stallreq = w_accept || (state_q == S_MUL) || (state_q == S_DIV);
    assign hilo_we  = (state_q == S_DONE) && !cancel;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sched
// Purpose  : Directed self-checking bench for the HI/LO multiply/divide engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sched;

    localparam logic [3:0] OP_MULT  = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_DIVU  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        stallreq, busy, hilo_we;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_cyc, we_cnt;
    logic [63:0] sr_trace, busy_trace;
    logic [31:0] hi_we, lo_we;

    muldiv_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stallreq (stallreq),
        .busy     (busy),
        .hilo_we  (hilo_we),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Entered at a falling edge (cycle 0). Holds start like EX does, records
    // per-cycle stallreq/busy and the DONE-cycle result. Returns one cycle after
    // DONE (at a falling edge), or mid-cycle stop_at, or after the cycle budget.
    task automatic drive_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int cancel_at, input int rst_at, input int stop_at,
                            input bit scramble);
        we_cyc = -1; we_cnt = 0; sr_trace = '0; busy_trace = '0;
        hi_we = 'x; lo_we = 'x;
        for (int c = 0; c < 48; c++) begin
            if (c == 0) begin
                start = 1'b1; op = o; src_a = a; src_b = b;
            end else if (scramble && busy) begin
                src_a = $urandom; src_b = $urandom; op = 4'($urandom);
            end
            cancel = (c == cancel_at);
            rst    = (c == rst_at);
            if ((cancel_at >= 0 && c > cancel_at) || (rst_at >= 0 && c > rst_at)) start = 1'b0;
            #1;
            sr_trace[c]   = stallreq;
            busy_trace[c] = busy;
            if (c == stop_at) return;
            if (hilo_we) begin
                we_cnt++; we_cyc = c; hi_we = hi; lo_we = lo;
                @(negedge clk);
                start = 1'b0; cancel = 1'b0; rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (stallreq !== 1'b0) $display("FAIL reset_stallreq: got %b want 0", stallreq); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (hilo_we !== 1'b0)  $display("FAIL reset_hilo_we: got %b want 0", hilo_we); else n_pass++;
        n_checks++; if (hi !== 32'h0)      $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0)      $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        drive_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
        n_checks++; if (sr_trace[33:0] !== 34'h1_FFFF_FFFF) $display("FAIL multu_stall_pattern: got %h want 1ffffffff", sr_trace[33:0]); else n_pass++;
        n_checks++; if (we_cyc !== 33) $display("FAIL multu_we_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if (hi_we !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want fffffffe", hi_we); else n_pass++;
        n_checks++; if (lo_we !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", lo_we); else n_pass++;
        #1;
        n_checks++; if ({stallreq, busy, hilo_we} !== 3'b000) $display("FAIL multu_after_done: got %b want 000", {stallreq, busy, hilo_we}); else n_pass++;
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu_hold: got %h want fffffffe00000001", {hi, lo}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_signed();
        drive_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, -1, -1, 1'b0);
        n_checks++; if (we_cyc !== 33) $display("FAIL mult_we_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if (hi_we !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", hi_we); else n_pass++;
        n_checks++; if (lo_we !== 32'hFFFF_FFF1) $display("FAIL mult_neg_lo: got %h want fffffff1", lo_we); else n_pass++;
        drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, 1'b0);
        n_checks++; if (we_cyc !== 33) $display("FAIL div_we_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if (lo_we !== 32'hFFFF_FFFD) $display("FAIL div_neg_quo: got %h want fffffffd", lo_we); else n_pass++;
        n_checks++; if (hi_we !== 32'hFFFF_FFFF) $display("FAIL div_neg_rem: got %h want ffffffff", hi_we); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_op(OP_DIVU, 32'd100, 32'd7, -1, -1, -1, 1'b0);
        n_checks++; if (lo_we !== 32'd14) $display("FAIL divu_quo: got %h want 0000000e", lo_we); else n_pass++;
        n_checks++; if (hi_we !== 32'd2)  $display("FAIL divu_rem: got %h want 00000002", hi_we); else n_pass++;
        n_checks++; if (we_cnt !== 1)     $display("FAIL divu_we_count: got %0d want 1", we_cnt); else n_pass++;
        drive_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
        n_checks++; if (sr_trace[0] !== 1'b1) $display("FAIL b2b_accept: got %b want 1", sr_trace[0]); else n_pass++;
        n_checks++; if (we_cyc !== 33) $display("FAIL b2b_we_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if (lo_we !== 32'h8000_0000) $display("FAIL div_ovf_quo: got %h want 80000000", lo_we); else n_pass++;
        n_checks++; if (hi_we !== 32'h0) $display("FAIL div_ovf_rem: got %h want 00000000", hi_we); else n_pass++;
    endtask

    task automatic test_div_zero();
        drive_op(OP_DIVU, 32'd5, 32'd0, -1, -1, -1, 1'b0);
        n_checks++; if (we_cyc !== 1) $display("FAIL dz_we_cycle: got %0d want 1", we_cyc); else n_pass++;
        n_checks++; if (sr_trace[1:0] !== 2'b01) $display("FAIL dz_stall_pattern: got %b want 01", sr_trace[1:0]); else n_pass++;
        n_checks++; if (hi_we !== 32'd5) $display("FAIL dz_hi: got %h want 00000005", hi_we); else n_pass++;
        n_checks++; if (lo_we !== 32'hFFFF_FFFF) $display("FAIL dz_lo: got %h want ffffffff", lo_we); else n_pass++;
    endtask

    task automatic test_cancel();
        drive_op(OP_MULT, 32'h0000_1234, 32'h0000_0010, 10, -1, 11, 1'b0);
        n_checks++; if (busy_trace[10] !== 1'b1) $display("FAIL cancel_busy_before: got %b want 1", busy_trace[10]); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL cancel_idle: got busy %b want 0", busy); else n_pass++;
        n_checks++; if (stallreq !== 1'b0) $display("FAIL cancel_stallreq: got %b want 0", stallreq); else n_pass++;
        n_checks++; if (we_cnt !== 0) $display("FAIL cancel_no_we: got %0d want 0", we_cnt); else n_pass++;
        n_checks++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL cancel_hold_hilo: got %h want 00000005ffffffff", {hi, lo}); else n_pass++;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9; cancel = 1'b1;
        #1;
        n_checks++; if (stallreq !== 1'b0) $display("FAIL cancel_at_sample_stall: got %b want 0", stallreq); else n_pass++;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL cancel_at_sample_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_op(OP_DIV, 32'd100, 32'd3, -1, 20, 21, 1'b0);
        n_checks++; if ({stallreq, busy, hilo_we} !== 3'b000) $display("FAIL rst_mid_ctrl: got %b want 000", {stallreq, busy, hilo_we}); else n_pass++;
        n_checks++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); else n_pass++;
        n_checks++; if (we_cnt !== 0) $display("FAIL rst_mid_no_we: got %0d want 0", we_cnt); else n_pass++;
        @(negedge clk);
        drive_op(OP_MULTU, 32'd3, 32'd4, -1, -1, -1, 1'b0);
        n_checks++; if (we_cyc !== 33) $display("FAIL rst_then_multu_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if ({hi_we, lo_we} !== {32'd0, 32'd12}) $display("FAIL rst_then_multu: got %h want 000000000000000c", {hi_we, lo_we}); else n_pass++;
    endtask

    task automatic test_isolation();
        int extra;
        drive_op(OP_MULT, 32'd7, 32'd6, -1, -1, -1, 1'b1);
        n_checks++; if (we_cyc !== 33) $display("FAIL iso_we_cycle: got %0d want 33", we_cyc); else n_pass++;
        n_checks++; if ({hi_we, lo_we} !== {32'd0, 32'd42}) $display("FAIL iso_result: got %h want 000000000000002a", {hi_we, lo_we}); else n_pass++;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (busy || hilo_we) extra++;
            @(negedge clk);
        end
        n_checks++; if (extra !== 0) $display("FAIL iso_no_relaunch: got %0d busy/we cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_invalid_op();
        start = 1'b1; op = 4'b0001; src_a = 32'd3; src_b = 32'd3;
        #1;
        n_checks++; if (stallreq !== 1'b0) $display("FAIL invalid_op_stall: got %b want 0", stallreq); else n_pass++;
        @(negedge clk);
        op = 4'b1001;
        #1;
        n_checks++; if ({stallreq, busy} !== 2'b00) $display("FAIL invalid_op_idle: got %b want 00", {stallreq, busy}); else n_pass++;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++; if ({busy, hilo_we} !== 2'b00) $display("FAIL invalid_op_no_action: got %b want 00", {busy, hilo_we}); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_back_to_back();
        test_div_zero();
        test_cancel();
        test_reset_mid();
        test_isolation();
        test_invalid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
